// File: rtl/floppy_pkg.sv
// Shared types and helpers for the floppy drive-control core.
package floppy_pkg;

  typedef enum logic [1:0] {OFF, SPINUP, READY} spin_state_t;

  localparam logic [3:0] PH0 = 4'b0001;
  localparam logic [3:0] PH1 = 4'b0010;
  localparam logic [3:0] PH2 = 4'b0100;
  localparam logic [3:0] PH3 = 4'b1000;

  // Synchronised single-bit bus/sensor pins, kept together so one flop pair handles them all.
  typedef struct packed {
    logic step;
    logic dir;
    logic motor;
    logic dens;
    logic in_use;
    logic ind;
    logic t00;
    logic wpr;
    logic dsk;
  } pin_t;

  // Active-low sensors idle high so reset does not fabricate an index fall or write-protect.
  localparam pin_t PIN_IDLE = '{step: 1'b0, dir: 1'b0, motor: 1'b0, dens: 1'b0, in_use: 1'b0,
                                ind: 1'b1, t00: 1'b0, wpr: 1'b1, dsk: 1'b0};

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic logic [3:0] ph_pat(input logic [1:0] p);
    case (p)
      2'd0:    ph_pat = PH0;
      2'd1:    ph_pat = PH1;
      2'd2:    ph_pat = PH2;
      default: ph_pat = PH3;
    endcase
  endfunction

endpackage

// File: rtl/step_seq.sv
// Stepper sequencer: step edge capture, one-deep pending, busy timer, coil phase and bounded track count.
module step_seq
  import floppy_pkg::*;
#(
  parameter int NUM_TRACKS = 80,
  parameter int TRK_W      = 7,
  parameter int STEP_CYC   = 30000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             step_s,
  input  logic             dir,
  input  logic             t00,
  output logic [3:0]       step_drv,
  output logic [TRK_W-1:0] trk_count,
  output logic             step_busy,
  output logic             step_ovf
);
  localparam int CW = clog2(STEP_CYC);

  logic          step_q, pending;
  logic [1:0]    ph, ph_nxt;
  logic [CW-1:0] cnt;
  logic          rise, take, at_max, ignore, exec;

  assign rise   = step_s & ~step_q & sel;
  assign take   = ~step_busy & (pending | rise);
  assign at_max = (trk_count == TRK_W'(NUM_TRACKS - 1));
  assign ignore = dir ? t00 : at_max;
  assign exec   = take & ~ignore;
  assign ph_nxt = dir ? ph - 2'd1 : ph + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      step_q    <= 1'b0;
      pending   <= 1'b0;
      ph        <= 2'd0;
      cnt       <= '0;
      step_drv  <= 4'b0000;
      trk_count <= '0;
      step_busy <= 1'b0;
      step_ovf  <= 1'b0;
    end else begin
      step_q <= step_s;
      // A new edge arriving while the pending one executes takes its slot.
      if (take)
        pending <= pending & rise;
      else if (rise) begin
        if (pending) step_ovf <= 1'b1;
        else         pending  <= 1'b1;
      end
      if (exec) begin
        step_busy <= 1'b1;
        cnt       <= CW'(STEP_CYC - 1);
        ph        <= ph_nxt;
        step_drv  <= ph_pat(ph_nxt);
      end else if (step_busy) begin
        if (cnt == '0) step_busy <= 1'b0;
        else           cnt       <= cnt - 1'b1;
      end
      // Track-00 sensor is authoritative over any step in the same cycle.
      if (t00)
        trk_count <= '0;
      else if (exec) begin
        if (dir) trk_count <= (trk_count == '0) ? '0 : trk_count - 1'b1;
        else     trk_count <= trk_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/drive_ctrl.sv
// Floppy drive-control core: input sync, select gating, spindle/ready FSM, stepper via step_seq.
// Optional: define DRIVE_CTRL_MOTOR_HOLD_EN to keep the spindle running MOTOR_HOLD cycles after motor_on falls.
module drive_ctrl
  import floppy_pkg::*;
#(
  parameter int NUM_DRIVES = 4,
  parameter int DRIVE_NUM  = 1,
  parameter int NUM_TRACKS = 80,
  parameter int TRK_W      = 7,
  parameter int STEP_CYC   = 30000,
  parameter int SPINUP_IDX = 2,
  parameter int MOTOR_HOLD = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DRIVES-1:0] drive_sel,
  input  logic                  motor_on,
  input  logic                  dens_sel,
  input  logic                  in_use,
  input  logic                  dir_sel,
  input  logic                  step,
  input  logic                  ind_sens,
  input  logic                  t00_sens,
  input  logic                  wpr_sens,
  input  logic                  dsk_sens,
  output logic                  index,
  output logic                  track_0,
  output logic                  wr_protect,
  output logic                  ready,
  output logic                  spin_en,
  output logic                  spin_ss,
  output logic [3:0]            step_drv,
  output logic                  head_load,
  output logic                  front_LED,
  output logic [TRK_W-1:0]      trk_count,
  output logic                  step_busy,
  output logic                  step_ovf
);
  localparam int IW = clog2(SPINUP_IDX + 1);

  logic [NUM_DRIVES-1:0] ds1, ds2;
  pin_t                  p_raw, p1, p2;
  logic                  ind_q, sel, ind_fall, motor_eff;
  spin_state_t           state, nxt;
  logic [IW-1:0]         idx_cnt, idx_nxt, idx_inc;

  assign p_raw = '{step: step, dir: dir_sel, motor: motor_on, dens: dens_sel, in_use: in_use,
                   ind: ind_sens, t00: t00_sens, wpr: wpr_sens, dsk: dsk_sens};

  always_ff @(posedge clk) begin
    if (!rst) begin
      ds1   <= '0;
      ds2   <= '0;
      p1    <= PIN_IDLE;
      p2    <= PIN_IDLE;
      ind_q <= 1'b1;
    end else begin
      ds1   <= drive_sel;
      ds2   <= ds1;
      p1    <= p_raw;
      p2    <= p1;
      ind_q <= p2.ind;
    end
  end

  assign sel      = ds2[DRIVE_NUM];
  assign ind_fall = ~p2.ind & ind_q;

`ifdef DRIVE_CTRL_MOTOR_HOLD_EN
  localparam int HW = clog2(MOTOR_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  logic          motor_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
      motor_q  <= 1'b0;
    end else begin
      motor_q <= p2.motor;
      if (!p2.dsk)                  hold_cnt <= '0;
      else if (motor_q & ~p2.motor) hold_cnt <= HW'(MOTOR_HOLD);
      else if (hold_cnt != '0)      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // motor_q bridges the single cycle between the synced fall and the counter reload.
  assign motor_eff = p2.motor | motor_q | (hold_cnt != '0);
`else
  assign motor_eff = p2.motor;
`endif

  assign idx_inc = idx_cnt + 1'b1;

  always_comb begin
    nxt     = state;
    idx_nxt = idx_cnt;
    if (!(motor_eff & p2.dsk)) begin
      nxt     = OFF;
      idx_nxt = '0;
    end else begin
      case (state)
        OFF:    begin nxt = SPINUP; idx_nxt = '0; end
        SPINUP: if (ind_fall) begin
                  idx_nxt = idx_inc;
                  if (idx_inc == IW'(SPINUP_IDX)) nxt = READY;
                end
        default: nxt = READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= OFF;
      idx_cnt    <= '0;
      index      <= 1'b0;
      track_0    <= 1'b0;
      wr_protect <= 1'b0;
      ready      <= 1'b0;
      spin_en    <= 1'b0;
      spin_ss    <= 1'b0;
      head_load  <= 1'b0;
      front_LED  <= 1'b0;
    end else begin
      state      <= nxt;
      idx_cnt    <= idx_nxt;
      index      <= ind_fall & sel;
      track_0    <= p2.t00 & sel;
      wr_protect <= ~p2.wpr & sel;
      ready      <= (nxt == READY) & sel;
      spin_en    <= (nxt != OFF);
      spin_ss    <= p2.dens;
      head_load  <= p2.in_use & sel;
      front_LED  <= (p2.in_use & sel) | (nxt != OFF);
    end
  end

  step_seq #(
    .NUM_TRACKS(NUM_TRACKS),
    .TRK_W     (TRK_W),
    .STEP_CYC  (STEP_CYC)
  ) u_step (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .step_s   (p2.step),
    .dir      (p2.dir),
    .t00      (p2.t00),
    .step_drv (step_drv),
    .trk_count(trk_count),
    .step_busy(step_busy),
    .step_ovf (step_ovf)
  );

endmodule

// File: tb/tb_drive_ctrl.sv
// Bench for drive_ctrl: sensor/select vector table, stepper model with random steps, spindle sequences.
module tb_drive_ctrl;
  localparam int NUM_DRIVES = 4;
  localparam int DRIVE_NUM  = 1;
  localparam int NUM_TRACKS = 8;
  localparam int TRK_W      = 3;
  localparam int STEP_CYC   = 20;
  localparam int SPINUP_IDX = 2;
  localparam int MOTOR_HOLD = 100;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_DRIVES-1:0] drive_sel;
  logic motor_on, dens_sel, in_use, dir_sel, step, ind_sens, t00_sens, wpr_sens, dsk_sens;
  logic index, track_0, wr_protect, ready, spin_en, spin_ss, head_load, front_LED, step_busy, step_ovf;
  logic [3:0] step_drv;
  logic [TRK_W-1:0] trk_count;

  drive_ctrl #(
    .NUM_DRIVES(NUM_DRIVES), .DRIVE_NUM(DRIVE_NUM), .NUM_TRACKS(NUM_TRACKS), .TRK_W(TRK_W),
    .STEP_CYC(STEP_CYC), .SPINUP_IDX(SPINUP_IDX), .MOTOR_HOLD(MOTOR_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .drive_sel(drive_sel), .motor_on(motor_on), .dens_sel(dens_sel),
    .in_use(in_use), .dir_sel(dir_sel), .step(step), .ind_sens(ind_sens), .t00_sens(t00_sens),
    .wpr_sens(wpr_sens), .dsk_sens(dsk_sens), .index(index), .track_0(track_0),
    .wr_protect(wr_protect), .ready(ready), .spin_en(spin_en), .spin_ss(spin_ss),
    .step_drv(step_drv), .head_load(head_load), .front_LED(front_LED), .trk_count(trk_count),
    .step_busy(step_busy), .step_ovf(step_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference stepper: physical head position and which coil is energised.
  int m_trk = 0;
  int m_ph  = 0;
  bit m_on  = 1'b0;

  typedef struct {
    logic [3:0] dsel;
    logic t00, wpr, dens, use_;
    logic e_t0, e_wp, e_ss, e_hl, e_led;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({index, track_0, wr_protect, ready, spin_en, spin_ss, step_drv, head_load,
                front_LED, trk_count, step_busy, step_ovf});
  endfunction

  function automatic logic [3:0] m_drv();
    return m_on ? 4'(1 << m_ph) : 4'b0000;
  endfunction

  // One step as the drive mechanics would see it, given whether this drive is selected.
  task automatic model_step(input bit out, input bit selected, input bit t00);
    if (!selected) return;
    if (out) begin
      if (t00) return;
      m_ph = (m_ph + 3) % 4;
      m_trk = (m_trk > 0) ? m_trk - 1 : 0;
    end else begin
      if (m_trk == NUM_TRACKS - 1) return;
      m_ph = (m_ph + 1) % 4;
      m_trk = m_trk + 1;
    end
    m_on = 1'b1;
  endtask

  task automatic pulse_step(input bit out);
    dir_sel = out;
    step = 1'b1;
    tick(2);
    step = 1'b0;
    tick(2);
  endtask

  task automatic do_step(input bit out);
    pulse_step(out);
    tick(STEP_CYC + 4);
    model_step(out, drive_sel[DRIVE_NUM], t00_sens);
  endtask

  task automatic index_pulse();
    ind_sens = 1'b0;
    tick(3);
    ind_sens = 1'b1;
    tick(6);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [3:0] held;
    bit busy_seen;

    rst = 1'b0; drive_sel = '0; motor_on = 0; dens_sel = 0; in_use = 0; dir_sel = 0; step = 0;
    ind_sens = 1; t00_sens = 0; wpr_sens = 1; dsk_sens = 0;
    tick(3);
    chk("reset_outputs", all_outs(), 32'd0);
    rst = 1'b1;
    tick(4);
    chk("idle_after_reset", all_outs(), 32'd0);

    vecs[0] = '{4'b0010, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    vecs[1] = '{4'b0001, 1, 0, 1, 1, 0, 0, 1, 0, 0};
    vecs[2] = '{4'b0010, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{4'b1111, 1, 1, 0, 1, 1, 0, 0, 1, 1};
    vecs[4] = '{4'b1101, 1, 0, 1, 1, 0, 0, 1, 0, 0};
    vecs[5] = '{4'b0010, 0, 0, 0, 1, 0, 1, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      drive_sel = vecs[i].dsel; t00_sens = vecs[i].t00; wpr_sens = vecs[i].wpr;
      dens_sel = vecs[i].dens; in_use = vecs[i].use_;
      tick(4);
      chk($sformatf("vec%0d_sensors", i),
          {27'd0, track_0, wr_protect, spin_ss, head_load, front_LED},
          {27'd0, vecs[i].e_t0, vecs[i].e_wp, vecs[i].e_ss, vecs[i].e_hl, vecs[i].e_led});
    end
    drive_sel = 4'b0010; t00_sens = 0; wpr_sens = 1; dens_sel = 0; in_use = 0;
    tick(4);

    // Three inward steps from reset: coils 0010, 0100, 1000; count 1..3.
    for (int i = 0; i < 3; i++) begin
      pulse_step(1'b0);
      chk($sformatf("busy_during_step%0d", i), 32'(step_busy), 32'd1);
      tick(STEP_CYC + 4);
      model_step(1'b0, 1'b1, 1'b0);
      chk($sformatf("inward%0d_drv", i), 32'(step_drv), 32'(4'b0010 << i));
      chk($sformatf("inward%0d_trk", i), 32'(trk_count), 32'(i + 1));
    end
    t00_sens = 1'b1;
    tick(4);
    chk("t00_forces_zero", 32'(trk_count), 32'd0);
    m_trk = 0;
    t00_sens = 1'b0;
    tick(4);

    // Walk to the last track, then probe both ignored-step boundaries.
    while (m_trk < NUM_TRACKS - 1) do_step(1'b0);
    chk("at_max_trk", 32'(trk_count), 32'(NUM_TRACKS - 1));
    held = step_drv;
    pulse_step(1'b0);
    busy_seen = step_busy;
    for (int i = 0; i < STEP_CYC; i++) begin tick(1); busy_seen |= step_busy; end
    chk("max_inward_busy", 32'(busy_seen), 32'd0);
    chk("max_inward_drv", 32'(step_drv), 32'(held));
    chk("max_inward_trk", 32'(trk_count), 32'(NUM_TRACKS - 1));
    t00_sens = 1'b1;
    tick(4);
    pulse_step(1'b1);
    busy_seen = step_busy;
    for (int i = 0; i < STEP_CYC; i++) begin tick(1); busy_seen |= step_busy; end
    chk("t00_outward_busy", 32'(busy_seen), 32'd0);
    chk("t00_outward_drv", 32'(step_drv), 32'(held));
    m_trk = 0;
    t00_sens = 1'b0;
    tick(4);
    do_step(1'b1);
    chk("outward_at0_drv", 32'(step_drv), 32'(m_drv()));
    chk("outward_at0_trk", 32'(trk_count), 32'd0);

    // Random steps, some while another drive is selected.
    for (int i = 0; i < 24; i++) begin
      drive_sel = ($urandom_range(0, 3) == 0) ? 4'b0101 : 4'b0010;
      tick(3);
      do_step(1'($urandom_range(0, 1)));
      chk($sformatf("rand%0d_drv", i), 32'(step_drv), 32'(m_drv()));
      chk($sformatf("rand%0d_trk", i), 32'(trk_count), 32'(m_trk));
    end
    drive_sel = 4'b0010;
    t00_sens = 1'b1; tick(4); t00_sens = 1'b0; tick(4);
    m_trk = 0;
    chk("ovf_clear_before", 32'(step_ovf), 32'd0);

    // Three edges in one busy window: two execute, the third overflows.
    pulse_step(1'b0); pulse_step(1'b0); pulse_step(1'b0);
    tick(2 * STEP_CYC + 10);
    model_step(1'b0, 1'b1, 1'b0);
    model_step(1'b0, 1'b1, 1'b0);
    chk("burst_trk", 32'(trk_count), 32'd2);
    chk("burst_drv", 32'(step_drv), 32'(m_drv()));
    chk("burst_ovf", 32'(step_ovf), 32'd1);

    // Reset while busy with a pending step.
    pulse_step(1'b0); pulse_step(1'b0);
    chk("midstep_busy", 32'(step_busy), 32'd1);
    rst = 1'b0;
    tick(1);
    chk("midstep_reset_outs", all_outs(), 32'd0);
    rst = 1'b1;
    tick(2 * STEP_CYC + 10);
    chk("no_pending_after_reset", {24'd0, step_drv, 1'b0, trk_count}, 32'd0);
    m_trk = 0; m_ph = 0; m_on = 1'b0;

    // Spindle: ready only after the second index fall.
    motor_on = 1'b1; dsk_sens = 1'b1;
    tick(5);
    chk("spinup_spin_en", 32'(spin_en), 32'd1);
    chk("spinup_not_ready", 32'(ready), 32'd0);
    index_pulse();
    chk("ready_after_1st_idx", 32'(ready), 32'd0);
    ind_sens = 1'b0;
    tick(2);
    chk("ready_before_2nd_fall", 32'(ready), 32'd0);
    tick(1);
    chk("ready_at_2nd_fall", 32'(ready), 32'd1);
    chk("index_pulse_high", 32'(index), 32'd1);
    tick(1);
    chk("index_pulse_one_cycle", 32'(index), 32'd0);
    ind_sens = 1'b1;
    drive_sel = 4'b0000;
    tick(4);
    chk("desel_ready", {30'd0, ready, spin_en}, 32'b01);
    drive_sel = 4'b0010;
    tick(4);
    chk("resel_ready", 32'(ready), 32'd1);
    dsk_sens = 1'b0;
    tick(3);
    chk("disk_out", {30'd0, ready, spin_en}, 32'd0);

    dsk_sens = 1'b1;
    tick(4);
    index_pulse(); index_pulse();
    chk("ready_again", 32'(ready), 32'd1);
    motor_on = 1'b0;
`ifdef DRIVE_CTRL_MOTOR_HOLD_EN
    tick(90);
    chk("hold_running", {30'd0, ready, spin_en}, 32'b11);
    tick(20);
    chk("hold_expired", {30'd0, ready, spin_en}, 32'd0);
`else
    tick(3);
    chk("motor_off", {30'd0, ready, spin_en}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
